sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO. It is the next generation of the team's FIFO family, for blocks that share one clock domain.
- Adds features the current FIFOs lack:
  - a selectable read mode: standard registered output, or first-word-fall-through (FWFT);
  - programmable almost-full and almost-empty thresholds;
  - an occupancy count;
  - sticky overflow and underflow error flags;
  - a synchronous flush.
- Sits between a producer and a consumer in the same clock domain.

---
 rtl/sync_fifo_param.sv | 118 +++++++++++
 tb/tb_sync_fifo_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with FWFT option, thresholds, count and sticky error flags
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   clear              synchronous flush, highest priority
//   wr_en, data_in     write request and data
//   full, almost_full  count == DEPTH, count >= AF_LEVEL
//   rd_en, data_out    read/pop request and read data
//   empty, almost_empty count == 0, count <= AE_LEVEL
//   count              occupancy 0..DEPTH
//   overflow/underflow sticky rejected-write / rejected-read flags
module sync_fifo_param #(
    parameter int DEPTH    = 8,
    parameter int DATASIZE = 4,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [DATASIZE-1:0]      data_in,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [DATASIZE-1:0]      data_out,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic                rd_acc, wr_acc;

    // Flags decode straight from the registered count.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read never completes from an empty FIFO; a write to a full FIFO
    // completes only when a read frees the slot on the same edge.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // FWFT shows the head word directly; the new word written into an
    // empty FIFO only becomes visible after its write edge.
    assign data_out = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr_q]) : dout_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wr_en & ~wr_acc);
        underflow_d = underflow_q | (rd_en & ~rd_acc);
        dout_d      = dout_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; writes are suppressed by clear and by rst.
    always_ff @(posedge clk) begin
        if (wr_acc && !clear && !rst) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
        end else if (clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench driving a standard and an FWFT instance in lockstep
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] data_in;

    logic       s_full, s_af, s_empty, s_ae, s_ov, s_un;
    logic [3:0] s_dout, s_count;
    logic       f_full, f_af, f_empty, f_ae, f_ov, f_un;
    logic [3:0] f_dout, f_count;

    always #5 clk = ~clk;

    sync_fifo_param #(.DEPTH(8), .DATASIZE(4), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(data_in),
        .full(s_full), .almost_full(s_af), .rd_en(rd_en), .data_out(s_dout),
        .empty(s_empty), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ov), .underflow(s_un)
    );

    sync_fifo_param #(.DEPTH(8), .DATASIZE(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(data_in),
        .full(f_full), .almost_full(f_af), .rd_en(rd_en), .data_out(f_dout),
        .empty(f_empty), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ov), .underflow(f_un)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    string      phase = "reset";

    logic [3:0] exp_q [$];
    bit         m_ov;
    bit         m_un;
    logic [3:0] m_sdout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = exp_q.size();
        chk("s_count", 32'(s_count), 32'(n));
        chk("f_count", 32'(f_count), 32'(n));
        chk("s_empty", 32'(s_empty), 32'(n == 0));
        chk("f_empty", 32'(f_empty), 32'(n == 0));
        chk("s_full", 32'(s_full), 32'(n == 8));
        chk("f_full", 32'(f_full), 32'(n == 8));
        chk("s_af", 32'(s_af), 32'(n >= 6));
        chk("f_af", 32'(f_af), 32'(n >= 6));
        chk("s_ae", 32'(s_ae), 32'(n <= 2));
        chk("f_ae", 32'(f_ae), 32'(n <= 2));
        chk("s_ov", 32'(s_ov), 32'(m_ov));
        chk("f_ov", 32'(f_ov), 32'(m_ov));
        chk("s_un", 32'(s_un), 32'(m_un));
        chk("f_un", 32'(f_un), 32'(m_un));
        chk("s_dout", 32'(s_dout), 32'(m_sdout));
        if (n > 0) begin
            chk("f_head", 32'(f_dout), 32'(exp_q[0]));
        end
    endtask

    // Called just after a falling edge: drives one cycle of stimulus,
    // advances the scoreboard at the rising edge, checks at the next fall.
    task automatic step(input bit wr, input logic [3:0] din, input bit rd, input bit clr);
        bit racc;
        bit wacc;
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        clear   = clr;
        racc = rd && (exp_q.size() != 0);
        wacc = wr && ((exp_q.size() != 8) || racc);
        #1;
        if (!clr && racc) begin
            chk("f_prepop", 32'(f_dout), 32'(exp_q[0]));
        end
        @(posedge clk);
        if (clr) begin
            exp_q.delete();
            m_ov    = 1'b0;
            m_un    = 1'b0;
            m_sdout = 4'h0;
        end else begin
            if (wr && !wacc) m_ov = 1'b1;
            if (rd && !racc) m_un = 1'b1;
            if (racc) m_sdout = exp_q.pop_front();
            if (wacc) exp_q.push_back(din);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
        #1;
        check_state();
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 4'h0;
        m_ov = 1'b0; m_un = 1'b0; m_sdout = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_state();

        phase = "fill_drain";
        for (int i = 1; i <= 9; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

        phase = "fwft_head";
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b1, 4'hB, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("f_after_pop", 32'(f_dout), 32'hB);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        phase = "full_wr_rd";
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        step(1'b1, 4'hF, 1'b1, 1'b0);
        chk("ov_clear", 32'(s_ov), 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("last_F", 32'(s_dout), 32'hF);

        phase = "empty_wr_rd";
        step(1'b1, 4'h5, 1'b1, 1'b0);
        chk("un_set", 32'(s_un), 32'h1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("got5", 32'(s_dout), 32'h5);

        phase = "wrap";
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            bit rd;
            bit wr;
            rd = (i % 2 == 1) || (exp_q.size() == 7);
            wr = (exp_q.size() < 7) || rd;
            if (exp_q.size() <= 1 && !wr) rd = 1'b0;
            step(wr, 4'(i), rd, 1'b0);
        end

        phase = "clear";
        step(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("pre_cnt5", 32'(s_count), 32'h5);
        chk("pre_ov", 32'(f_ov), 32'h1);
        step(1'b1, 4'hE, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 7), 1'b0, 1'b0);
        chk("head_not_E", 32'(f_dout), 32'h7);

        phase = "async_rst";
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        m_sdout = 4'h0;
        check_state();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state();
        step(1'b1, 4'h6, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
